// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Debounces one mechanical push-button for the Snake Game control logic.
// The raw pad level is first synchronized into the clk domain through a
// SYNC_STAGES-deep flop chain. A four-state FSM then only lets button_out
// follow the synchronized level after it has differed from button_out on
// DEBOUNCE_CYCLES consecutive rising edges. A single sample that agrees with
// button_out restarts the count.
//
// Optional feature (macro BUTTON_DEBOUNCER_EDGE_EN):
//   adds press_pulse / release_pulse, one-cycle registered strobes that are
//   high in the same cycle button_out changes 0->1 / 1->0.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   button_in     in   raw, asynchronous, bouncy level (1 = pressed)
//   button_out    out  debounced, registered level
//   press_pulse   out  one-cycle strobe on debounced 0->1 (EDGE_EN only)
//   release_pulse out  one-cycle strobe on debounced 1->0 (EDGE_EN only)
//
// Debug: fsm_q is a packed struct {state, cnt} holding the whole FSM state,
// so checkers can bind to it directly.
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_out
`ifdef BUTTON_DEBOUNCER_EDGE_EN
  ,
  output logic press_pulse,
  output logic release_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    state_e                 state;
    logic [CNT_WIDTH-1:0]   cnt;
  } fsm_t;

  // Count value on which the next differing sample accepts the change.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the first differing sample accepts directly,
  // so the WAIT states are never entered.
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  fsm_t                   fsm_q, fsm_d;
  logic                   button_out_q, button_out_d;

  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], button_in};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q.state)
      IDLE: begin
        if (sync_q) begin
          if (SINGLE_CYCLE) begin
            fsm_d.state = PRESSED;
            fsm_d.cnt   = '0;
          end else begin
            fsm_d.state = PRESS_WAIT;
            fsm_d.cnt   = CNT_WIDTH'(1);
          end
        end else begin
          fsm_d.cnt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          fsm_d.state = IDLE;
          fsm_d.cnt   = '0;
        end else if (fsm_q.cnt == CNT_LAST) begin
          fsm_d.state = PRESSED;
          fsm_d.cnt   = '0;
        end else begin
          fsm_d.cnt = fsm_q.cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          if (SINGLE_CYCLE) begin
            fsm_d.state = IDLE;
            fsm_d.cnt   = '0;
          end else begin
            fsm_d.state = RELEASE_WAIT;
            fsm_d.cnt   = CNT_WIDTH'(1);
          end
        end else begin
          fsm_d.cnt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          fsm_d.state = PRESSED;
          fsm_d.cnt   = '0;
        end else if (fsm_q.cnt == CNT_LAST) begin
          fsm_d.state = IDLE;
          fsm_d.cnt   = '0;
        end else begin
          fsm_d.cnt = fsm_q.cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        fsm_d.state = IDLE;
        fsm_d.cnt   = '0;
      end
    endcase
  end

  // The debounced level is 1 exactly in the states that follow an accepted
  // press; registering it from the next state keeps it glitch-free.
  assign button_out_d = (fsm_d.state == PRESSED) || (fsm_d.state == RELEASE_WAIT);

`ifdef BUTTON_DEBOUNCER_EDGE_EN
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;

  assign press_pulse_d   = button_out_d & ~button_out_q;
  assign release_pulse_d = ~button_out_d & button_out_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain_q    <= '0;
      fsm_q           <= '{state: IDLE, cnt: '0};
      button_out_q    <= 1'b0;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
`endif
    end else begin
      sync_chain_q    <= sync_chain_d;
      fsm_q           <= fsm_d;
      button_out_q    <= button_out_d;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
`endif
    end
  end

  assign button_out = button_out_q;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2,
// 100 ns clock). Inputs change and outputs are sampled on the falling edge.
// A reference model keeps a queue of button_in samples delayed by the
// synchronizer depth and applies the acceptance rule directly: the output
// flips after DEBOUNCE_CYCLES consecutive edges on which the delayed sample
// differs from it.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DEB - 1;  // edges from input change to output change

  logic clk;
  logic reset;
  logic button_in;
  logic button_out;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
  logic press_pulse;
  logic release_pulse;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_in     (button_in),
    .button_out    (button_out)
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    ,
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ---------------- reference model ----------------
  bit samp_q[$];
  bit m_seen;
  bit m_out;
  bit m_press;
  bit m_release;
  int m_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q = {};
      for (int i = 0; i < SYNC; i++) samp_q.push_back(1'b0);
      m_out     = 1'b0;
      m_run     = 0;
      m_press   = 1'b0;
      m_release = 1'b0;
    end else begin
      m_seen = samp_q.pop_front();
      samp_q.push_back(button_in);
      m_press   = 1'b0;
      m_release = 1'b0;
      if (m_seen != m_out) begin
        m_run++;
        if (m_run == DEB) begin
          m_out = ~m_out;
          m_run = 0;
          if (m_out) m_press = 1'b1;
          else       m_release = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // ---------------- driver tasks (no checking) ----------------
  // Drive a level and let n falling edges pass.
  task automatic hold(input logic level, input int n);
    button_in = level;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    button_in = 1'b0;
    #10;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if (button_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: button_out=%b expected 0", c, button_out);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    button_in = 1'b1;  // before edge k
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);  // after edge k+e
      tests_run++;
      if (button_out !== (e >= LAT)) begin
        tests_failed++;
        $display("FAIL clean_press edge k+%0d: button_out=%b expected %b", e, button_out, e >= LAT);
      end
      tests_run++;
      if (button_out !== m_out) begin
        tests_failed++;
        $display("FAIL clean_press_model edge k+%0d: button_out=%b model %b", e, button_out, m_out);
      end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
      if (press_pulse === 1'b1) pulses++;
      tests_run++;
      if (press_pulse !== (e == LAT) || release_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL clean_press_pulse edge k+%0d: press=%b release=%b expected %b/0",
                 e, press_pulse, release_pulse, e == LAT);
      end
`endif
    end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL clean_press_pulse_count: got %0d expected 1", pulses);
    end
`endif
  endtask

  task automatic test_async_reset();
    // Output is 1 here; reset must clear it without a clock edge.
    #10;
    reset = 1'b1;
    #1;
    tests_run++;
    if (button_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: button_out=%b expected 0 before any clock", button_out);
    end
    button_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int seq_len[4] = '{3, 1, 2, 8};
    logic seq_lvl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    hold(1'b0, 8);
    for (int s = 0; s < 4; s++) begin
      button_in = seq_lvl[s];
      for (int c = 0; c < seq_len[s]; c++) begin
        @(negedge clk);
        tests_run++;
        if (button_out !== 1'b0 || m_out !== 1'b0) begin
          tests_failed++;
          $display("FAIL bounce seg %0d cycle %0d: button_out=%b model %b expected 0",
                   s, c, button_out, m_out);
        end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
        if (press_pulse === 1'b1 || release_pulse === 1'b1) pulses++;
`endif
      end
    end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL bounce_pulses: got %0d expected 0", pulses);
    end
`endif
  endtask

  task automatic test_clean_release();
    int pulses = 0;
    hold(1'b1, LAT + 4);
    button_in = 1'b0;  // before edge k
    for (int e = 0; e < 9; e++) begin
      @(negedge clk);
      tests_run++;
      if (button_out !== (e < LAT)) begin
        tests_failed++;
        $display("FAIL clean_release edge k+%0d: button_out=%b expected %b", e, button_out, e < LAT);
      end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
      if (release_pulse === 1'b1) pulses++;
      tests_run++;
      if (release_pulse !== (e == LAT) || press_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL clean_release_pulse edge k+%0d: release=%b press=%b expected %b/0",
                 e, release_pulse, press_pulse, e == LAT);
      end
`endif
    end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL clean_release_pulse_count: got %0d expected 1", pulses);
    end
`endif
  endtask

  task automatic test_release_glitch();
    hold(1'b1, LAT + 4);
    button_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) button_in = 1'b1;  // low for exactly 3 sampled edges
      tests_run++;
      if (button_out !== 1'b1 || m_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL release_glitch cycle %0d: button_out=%b model %b expected 1",
                 c, button_out, m_out);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    hold(1'b0, 10);
    button_in = 1'b1;       // before edge k
    repeat (4) @(negedge clk);  // after edge k+3: PRESS_WAIT, count 2
    #10;
    reset = 1'b1;
    #1;
    tests_run++;
    if (button_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_count: button_out=%b expected 0", button_out);
    end
    @(negedge clk);
    reset = 1'b0;           // button_in still 1; next edge is j
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      tests_run++;
      if (button_out !== (e >= LAT)) begin
        tests_failed++;
        $display("FAIL reset_mid_count_relatch edge j+%0d: button_out=%b expected %b",
                 e, button_out, e >= LAT);
      end
    end
  endtask

  task automatic test_random();
    int cycles = 0;
    while (cycles < 600) begin
      button_in = 1'($urandom_range(0, 1));
      for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
        @(negedge clk);
        cycles++;
        tests_run++;
        if (button_out !== m_out) begin
          tests_failed++;
          $display("FAIL random cycle %0d: button_out=%b model %b", cycles, button_out, m_out);
        end
`ifdef BUTTON_DEBOUNCER_EDGE_EN
        tests_run++;
        if (press_pulse !== m_press || release_pulse !== m_release ||
            (press_pulse === 1'b1 && release_pulse === 1'b1)) begin
          tests_failed++;
          $display("FAIL random_pulse cycle %0d: press=%b release=%b model %b/%b",
                   cycles, press_pulse, release_pulse, m_press, m_release);
        end
`endif
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset     = 1'b1;
    button_in = 1'b0;
    test_reset();
    test_clean_press();
    test_async_reset();
    test_bounce();
    test_clean_release();
    test_release_glitch();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
